alu_op_decoder: RTL and testbench

Registered instruction-decode stage that produces the 4-bit ALU select code, immediate and operand-source controls consumed by the ALU. It takes 32-bit RV32I instruction words over a valid/ready handshake and emits one decoded bundle per instruction, in order, through a two-entry skid buffer. It sits between instruction fetch and the ALU/operand mux, with full throughput under backpressure.

---
 rtl/alu_op_decoder_if.sv | 28 ++
 rtl/alu_op_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_decoder_if.sv
// Decode-stage bus: fetch-side valid/ready instruction input plus the decoded bundle output.
// Ports: in_valid/in_ready/instr (from fetch), out_valid/out_ready + alu_sel/use_imm/a_is_pc/imm/rd/rs1/rs2/illegal (to ALU).
// The slave modport is the decoder's view; master is the surrounding fetch/ALU (or bench) view.
interface alu_op_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic        use_imm;
  logic        a_is_pc;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_sel, use_imm, a_is_pc, imm, rd, rs1, rs2, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_sel, use_imm, a_is_pc, imm, rd, rs1, rs2, illegal
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Purpose: RV32I decode stage producing ALU select, immediate and operand-source controls.
// Latency: one cycle from input accept to output when the output slot is empty or draining.
// Backpressure: two-entry skid buffer; in_ready is registered (= skid empty), full throughput.
// Ports: clk, rst_n (async active-low), flush (sync, top priority), bus (alu_op_decoder_if.slave).
module alu_op_decoder (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  alu_op_decoder_if.slave bus
);

  typedef struct packed {
    logic [3:0]  alu_sel;
    logic        use_imm;
    logic        a_is_pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] SEL_ADD    = 4'd0;
  localparam logic [3:0] SEL_SUB    = 4'd1;
  localparam logic [3:0] SEL_SLL    = 4'd2;
  localparam logic [3:0] SEL_SLT    = 4'd3;
  localparam logic [3:0] SEL_SLTU   = 4'd4;
  localparam logic [3:0] SEL_XOR    = 4'd5;
  localparam logic [3:0] SEL_SRL    = 4'd6;
  localparam logic [3:0] SEL_SRA    = 4'd7;
  localparam logic [3:0] SEL_OR     = 4'd8;
  localparam logic [3:0] SEL_AND    = 4'd9;
  localparam logic [3:0] SEL_PASS_B = 4'd15;

  // funct3 -> ALU op for R/I arithmetic; alt selects sub/sra (funct7 = 0100000).
  function automatic logic [3:0] f3_to_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_sel = alt ? SEL_SUB : SEL_ADD;
      3'b001:  f3_to_sel = SEL_SLL;
      3'b010:  f3_to_sel = SEL_SLT;
      3'b011:  f3_to_sel = SEL_SLTU;
      3'b100:  f3_to_sel = SEL_XOR;
      3'b101:  f3_to_sel = alt ? SEL_SRA : SEL_SRL;
      3'b110:  f3_to_sel = SEL_OR;
      default: f3_to_sel = SEL_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign funct7  = bus.instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25],
                  bus.instr[11:8], 1'b0};
  assign imm_u = {bus.instr[31:12], 12'b0};
  assign imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                  bus.instr[30:21], 1'b0};

  dec_t dec;

  // Starts as the "illegal" bundle; each legal format overrides it. Register
  // indices are always copied so a trapping stage can still report them.
  // The opcode compare includes instr[1:0], so non-32-bit encodings fall to default.
  always_comb begin
    dec         = '0;
    dec.alu_sel = SEL_PASS_B;
    dec.illegal = 1'b1;
    dec.rd      = bus.instr[11:7];
    dec.rs1     = bus.instr[19:15];
    dec.rs2     = bus.instr[24:20];
    case (opcode)
      OP_R: begin
        if (f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.illegal = 1'b0;
          dec.alu_sel = f3_to_sel(funct3, f7_alt);
        end
      end
      OP_I: begin
        if (funct3 == 3'b001) begin
          if (f7_zero) begin
            dec.illegal = 1'b0;
            dec.alu_sel = SEL_SLL;
            dec.use_imm = 1'b1;
            dec.imm     = {27'b0, bus.instr[24:20]};
          end
        end else if (funct3 == 3'b101) begin
          if (f7_zero || f7_alt) begin
            dec.illegal = 1'b0;
            dec.alu_sel = f7_alt ? SEL_SRA : SEL_SRL;
            dec.use_imm = 1'b1;
            dec.imm     = {27'b0, bus.instr[24:20]};
          end
        end else begin
          // Non-shift immediates: upper bits are immediate, never a sub selector.
          dec.illegal = 1'b0;
          dec.alu_sel = f3_to_sel(funct3, 1'b0);
          dec.use_imm = 1'b1;
          dec.imm     = imm_i;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec.illegal = 1'b0;
        dec.alu_sel = SEL_ADD;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
      end
      OP_STORE: begin
        dec.illegal = 1'b0;
        dec.alu_sel = SEL_ADD;
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
      end
      OP_LUI: begin
        dec.illegal = 1'b0;
        dec.alu_sel = SEL_PASS_B;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OP_AUIPC: begin
        dec.illegal = 1'b0;
        dec.alu_sel = SEL_ADD;
        dec.use_imm = 1'b1;
        dec.a_is_pc = 1'b1;
        dec.imm     = imm_u;
      end
      OP_JAL: begin
        dec.illegal = 1'b0;
        dec.alu_sel = SEL_ADD;
        dec.use_imm = 1'b1;
        dec.a_is_pc = 1'b1;
        dec.imm     = imm_j;
      end
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec.illegal = 1'b0;
          dec.imm     = imm_b;
          if (funct3[2:1] == 2'b00)      dec.alu_sel = SEL_SUB;
          else if (funct3[2:1] == 2'b10) dec.alu_sel = SEL_SLT;
          else                           dec.alu_sel = SEL_SLTU;
        end
      end
      default: ;
    endcase
  end

  dec_t main_dat, skid_dat;
  logic main_vld, skid_vld;
  logic in_fire;
  logic main_free;

  // Skid only fills while main is stalled, so "skid empty" is a safe registered ready.
  assign in_fire   = bus.in_valid & ~skid_vld;
  assign main_free = ~main_vld | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        // Older word in skid goes first; input is blocked while skid is full.
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        main_dat <= dec;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_dat <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_vld;
  assign bus.out_valid = main_vld;
  assign bus.alu_sel   = main_dat.alu_sel;
  assign bus.use_imm   = main_dat.use_imm;
  assign bus.a_is_pc   = main_dat.a_is_pc;
  assign bus.imm       = main_dat.imm;
  assign bus.rd        = main_dat.rd;
  assign bus.rs1       = main_dat.rs1;
  assign bus.rs2       = main_dat.rs2;
  assign bus.illegal   = main_dat.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed test-plan sequences followed by random traffic,
// all checked against an arithmetic reference decoder and an in-order queue of
// accepted instructions (queue depth stands in for buffer occupancy).
module tb_alu_op_decoder;

  typedef struct packed {
    logic [3:0]  sel;
    logic        use_imm;
    logic        a_is_pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } exp_t;

  localparam int ALU_OF_F3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                      7'h37, 7'h17, 7'h6f, 7'h63, 7'h13};

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  alu_op_decoder_if bus ();

  alu_op_decoder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  int   emitted[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Reference decode, straight from the instruction-set rules using integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   f3, f7, op, sw, v;
    logic legal;
    sw = w;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    legal = 1'b0;
    v = 0;
    e = '0;
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    case (op)
      'h33: begin
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.sel = 4'(ALU_OF_F3[f3] + ((f7 == 32) ? 1 : 0));
      end
      'h13: begin
        if (f3 == 1)      legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0 || f7 == 32);
        else              legal = 1'b1;
        e.sel = 4'(ALU_OF_F3[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
        e.use_imm = 1'b1;
        v = (f3 == 1 || f3 == 5) ? int'(w[24:20]) : (sw >>> 20);
      end
      'h03, 'h67: begin
        legal = 1'b1; e.sel = 0; e.use_imm = 1'b1; v = sw >>> 20;
      end
      'h23: begin
        legal = 1'b1; e.sel = 0; e.use_imm = 1'b1;
        v = ((sw >>> 25) * 32) + int'(w[11:7]);
      end
      'h37: begin
        legal = 1'b1; e.sel = 15; e.use_imm = 1'b1; v = int'(w & 32'hFFFFF000);
      end
      'h17: begin
        legal = 1'b1; e.sel = 0; e.use_imm = 1'b1; e.a_is_pc = 1'b1;
        v = int'(w & 32'hFFFFF000);
      end
      'h6f: begin
        legal = 1'b1; e.sel = 0; e.use_imm = 1'b1; e.a_is_pc = 1'b1;
        v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
      end
      'h63: begin
        legal = (f3 != 2 && f3 != 3);
        e.sel = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
        v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
            + int'(w[11:8]) * 2;
      end
      default: legal = 1'b0;
    endcase
    e.imm = v;
    if (!legal) begin
      e.sel = 15; e.use_imm = 1'b0; e.a_is_pc = 1'b0; e.imm = '0; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // One clock: drive inputs, check outputs against the model at the falling edge,
  // then advance the model on the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    logic in_fire, out_fire;
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("alu_sel", 32'(bus.alu_sel), 32'(q[0].sel));
      chk("use_imm", 32'(bus.use_imm), 32'(q[0].use_imm));
      chk("a_is_pc", 32'(bus.a_is_pc), 32'(q[0].a_is_pc));
      chk("imm",     bus.imm,          q[0].imm);
      chk("regs",    32'({bus.rd, bus.rs1, bus.rs2}), 32'({q[0].rd, q[0].rs1, q[0].rs2}));
      chk("illegal", 32'(bus.illegal), 32'(q[0].illegal));
    end
    in_fire  = iv && (q.size() < 2);
    out_fire = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (out_fire) begin
        emitted.push_back(int'(q[0].rd));
        void'(q.pop_front());
      end
      if (in_fire) q.push_back(ref_decode(ins));
    end
    #1;
  endtask

  function automatic logic [31:0] addi_rd(input int n);
    logic [31:0] w;
    w = 32'h00000013 | (32'(n) << 7) | (32'(n) << 20);
    return w;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = OPS[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_alu_sel",   32'(bus.alu_sel),   32'd0);
    chk("rst_imm",       bus.imm,            32'd0);
    rst_n = 1'b1;

    // add x3,x1,x2 : one cycle latency
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_sel",   32'(bus.alu_sel),   32'd0);
    chk("add_regs",  32'({bus.rd, bus.rs1, bus.rs2}), 32'({5'd3, 5'd1, 5'd2}));
    chk("add_ill",   32'(bus.illegal),   32'd0);

    // sub, srai, addi back to back
    cycle(1'b1, 32'h402081B3, 1'b1, 1'b0);
    chk("sub_sel", 32'(bus.alu_sel), 32'd1);
    cycle(1'b1, 32'h40435293, 1'b1, 1'b0);
    chk("srai_sel", 32'(bus.alu_sel), 32'd7);
    chk("srai_imm", bus.imm, 32'd4);
    chk("srai_use_imm", 32'(bus.use_imm), 32'd1);
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi_sel", 32'(bus.alu_sel), 32'd0);
    chk("addi_imm", bus.imm, 32'hFFFFFFFF);

    cycle(1'b1, 32'h123450B7, 1'b1, 1'b0);
    chk("lui_sel", 32'(bus.alu_sel), 32'd15);
    chk("lui_imm", bus.imm, 32'h12345000);
    chk("lui_use_imm", 32'(bus.use_imm), 32'd1);

    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("ill1_flag", 32'(bus.illegal), 32'd1);
    chk("ill1_sel",  32'(bus.alu_sel), 32'd15);
    chk("ill1_ctl",  32'({bus.use_imm, bus.a_is_pc}), 32'd0);
    chk("ill1_imm",  bus.imm, 32'd0);
    cycle(1'b1, 32'h4020A1B3, 1'b1, 1'b0);
    chk("ill2_flag", 32'(bus.illegal), 32'd1);
    chk("ill2_sel",  32'(bus.alu_sel), 32'd15);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure: two accepted, third held, then in-order drain
    emitted.delete();
    cycle(1'b1, addi_rd(10), 1'b0, 1'b0);
    cycle(1'b1, addi_rd(11), 1'b0, 1'b0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, addi_rd(12), 1'b0, 1'b0);
    chk("held_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, addi_rd(12), 1'b1, 1'b0);
    chk("reopen_in_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, addi_rd(12), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("order_count", 32'(emitted.size()), 32'd3);
    if (emitted.size() == 3) chk("order_seq", 32'({emitted[0][7:0], emitted[1][7:0], emitted[2][7:0]}),
                                 32'h000A0B0C);

    // flush while full
    cycle(1'b1, addi_rd(20), 1'b0, 1'b0);
    cycle(1'b1, addi_rd(21), 1'b0, 1'b0);
    cycle(1'b1, addi_rd(22), 1'b0, 1'b1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
    cycle(1'b1, addi_rd(23), 1'b0, 1'b0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
    chk("post_flush_rd",    32'(bus.rd), 32'd23);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    cycle(1'b1, addi_rd(5), 1'b0, 1'b0);
    cycle(1'b1, addi_rd(6), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
